commit_trace_monitor: RTL

Debug/verification block for the MIPS SOPC. It observes the CPU's GPR, HI and LO writeback ports and keeps a shadow register file readable by address. Each cycle with at least one architectural write is captured as a timestamped entry in a trace FIFO with a valid/ready drain. A run ends on a programmable halt PC or cycle limit, replacing fixed-delay simulation stops with a deterministic `done` indication.

---
 rtl/commit_trace_monitor.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: shadow GPR/HI/LO file plus timestamped commit trace FIFO.
// Ends a run on halt PC or cycle limit and reports done once the trace drains.
module commit_trace_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           cycle_limit,
  input  logic [DATA_WIDTH-1:0] halt_pc,
  input  logic                  halt_pc_valid,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  wb_write_enable,
  input  logic [AW-1:0]         wb_write_address,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  hi_write_enable,
  input  logic [DATA_WIDTH-1:0] hi_write_data,
  input  logic                  lo_write_enable,
  input  logic [DATA_WIDTH-1:0] lo_write_data,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [2:0]            trace_mask,
  output logic [AW-1:0]         trace_address,
  output logic [DATA_WIDTH-1:0] trace_gpr_data,
  output logic [DATA_WIDTH-1:0] trace_hi_data,
  output logic [DATA_WIDTH-1:0] trace_lo_data,
  output logic [31:0]           trace_cycle,
  input  logic [AW-1:0]         shadow_read_address,
  output logic [DATA_WIDTH-1:0] shadow_read_data,
  output logic [DATA_WIDTH-1:0] shadow_hi,
  output logic [DATA_WIDTH-1:0] shadow_lo,
  output logic                  done,
  output logic [1:0]            done_cause,
  output logic                  overflow,
  output logic [31:0]           write_count,
  output logic [31:0]           cycle_count
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0] PTR_ONE = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [2:0]            mask;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] gpr;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic [31:0]           cyc;
  } entry_t;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shadow_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  entry_t                fifo_mem [FIFO_DEPTH];
  entry_t                new_entry;
  entry_t                head;
  logic [FAW:0]          wr_ptr;
  logic [FAW:0]          rd_ptr;

  logic       fifo_empty;
  logic       fifo_full;
  logic       running;
  logic       abort;
  logic       gpr_we;
  logic       gpr_in_range;
  logic [2:0] mask;
  logic       capture;
  logic       hit_pc;
  logic       hit_lim;
  logic       pop;
  logic       push;
  logic       drop;
  logic [31:0] wc_inc;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FAW] != rd_ptr[FAW]) &&
                      (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]);

  assign running = (state == S_RUN) && enable;
  assign abort   = ((state == S_RUN) || (state == S_DRAIN)) && !enable;

  assign gpr_we       = wb_write_enable && (wb_write_address != '0);
  assign gpr_in_range = int'(wb_write_address) < REG_COUNT;
  assign mask    = running ? {lo_write_enable, hi_write_enable, gpr_we} : 3'b000;
  assign capture = |mask;

  assign hit_pc  = halt_pc_valid && (pc == halt_pc);
  assign hit_lim = (cycle_limit != '0) && (cycle_count == cycle_limit - 32'd1);

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop  = !fifo_empty && trace_ready;
  assign push = capture && (!fifo_full || pop);
  assign drop = capture && fifo_full && !pop;

  assign wc_inc = 32'(mask[0]) + 32'(mask[1]) + 32'(mask[2]);

  always_comb begin
    new_entry      = '0;
    new_entry.mask = mask;
    new_entry.cyc  = cycle_count;
    if (mask[0]) begin
      new_entry.addr = wb_write_address;
      new_entry.gpr  = wb_write_data;
    end
    if (mask[1]) new_entry.hi = hi_write_data;
    if (mask[2]) new_entry.lo = lo_write_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cycle_count <= '0;
      write_count <= '0;
      overflow    <= 1'b0;
      done_cause  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state       <= S_RUN;
            cycle_count <= '0;
            write_count <= '0;
            overflow    <= 1'b0;
            done_cause  <= '0;
          end
        end
        S_RUN: begin
          if (!enable) begin
            state      <= S_IDLE;
            done_cause <= '0;
          end else begin
            write_count <= write_count + wc_inc;
            if (drop) overflow <= 1'b1;
            if (hit_pc || hit_lim) begin
              state      <= S_DRAIN;
              done_cause <= {hit_lim, hit_pc};
            end else begin
              cycle_count <= cycle_count + 32'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!enable) begin
            state      <= S_IDLE;
            done_cause <= '0;
          end else if (fifo_empty) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) shadow_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state == S_IDLE) && enable) begin
      for (int i = 0; i < REG_COUNT; i++) shadow_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (mask[0] && gpr_in_range) shadow_q[wb_write_address] <= wb_write_data;
      if (mask[1]) hi_q <= hi_write_data;
      if (mask[2]) lo_q <= lo_write_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[FAW-1:0]] <= new_entry;
  end

  // Payload is forced to zero while empty so stale storage never leaks out.
  assign head           = fifo_mem[rd_ptr[FAW-1:0]];
  assign trace_valid    = !fifo_empty;
  assign trace_mask     = trace_valid ? head.mask : '0;
  assign trace_address  = trace_valid ? head.addr : '0;
  assign trace_gpr_data = trace_valid ? head.gpr  : '0;
  assign trace_hi_data  = trace_valid ? head.hi   : '0;
  assign trace_lo_data  = trace_valid ? head.lo   : '0;
  assign trace_cycle    = trace_valid ? head.cyc  : '0;

  assign shadow_read_data = (int'(shadow_read_address) < REG_COUNT) ?
                            shadow_q[shadow_read_address] : '0;
  assign shadow_hi = hi_q;
  assign shadow_lo = lo_q;
  assign done      = (state == S_DONE);

endmodule
